// File: rtl/psoc_dac_sched.sv
// rtl/psoc_dac_sched.sv - sample scheduler sharing the psoc_dac sample port between two stereo sources
//
// Holds the sample presented to psoc_dac, refills it after every DAC read pulse and
// selects, prioritises or mixes the two sources. Flags underruns.
//
// Optional feature macro: PSOC_DAC_SCHED_STATS_EN (adds clr_stats / underrun_cnt).
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   mode[1:0]           0=s0 only, 1=s1 only, 2=priority s1 over s0, 3=mix s0+s1
//   mute                load a zero sample (sources are still consumed)
//   s0_data/valid/ready CPU/DMA stereo source, [23:0] left, [47:24] right
//   s1_data/valid/ready tone generator stereo source, same format
//   dac_data[47:0]      sample presented to psoc_dac fifo_data
//   dac_ready           psoc_dac fifo_ready, one-cycle pulse = dac_data consumed
//   underrun            one-cycle pulse per underrun event
//   clr_stats           (stats build) clear underrun counter, wins over increment
//   underrun_cnt        (stats build) saturating underrun counter

module psoc_dac_sched #(
   parameter int TIMEOUT = 1024
`ifdef PSOC_DAC_SCHED_STATS_EN
   , parameter int CNT_W = 16
`endif
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  mode,
   input  logic        mute,
   input  logic [47:0] s0_data,
   input  logic        s0_valid,
   output logic        s0_ready,
   input  logic [47:0] s1_data,
   input  logic        s1_valid,
   output logic        s1_ready,
   output logic [47:0] dac_data,
   input  logic        dac_ready,
   output logic        underrun
`ifdef PSOC_DAC_SCHED_STATS_EN
   , input  logic             clr_stats
   , output logic [CNT_W-1:0] underrun_cnt
`endif
);

   typedef enum logic [1:0] {
      ST_WAIT  = 2'd0,
      ST_FETCH = 2'd1,
      ST_LOAD  = 2'd2
   } state_t;

   localparam int TW = 11;
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

   state_t          state_q, state_d;
   logic [1:0]      mode_q, mode_d;
   logic            mute_q, mute_d;
   logic [TW-1:0]   cnt_q, cnt_d;
   logic            got0_q, got0_d, got1_q, got1_d;
   logic [47:0]     cap0_q, cap0_d, cap1_q, cap1_d;
   logic [47:0]     dac_q, dac_d;
   logic            load_und;
   logic            req0, req1, done;
   logic [47:0]     src0, src1, mix;

   // Signed 24-bit add with saturation to the 24-bit range.
   function automatic logic [23:0] sat_add(input logic [23:0] a, input logic [23:0] b);
      logic [24:0] s;
      s = {a[23], a} + {b[23], b};
      if (s[24] != s[23]) begin
         sat_add = s[24] ? 24'h800000 : 24'h7FFFFF;
      end else begin
         sat_add = s[23:0];
      end
   endfunction

   // Missing sources contribute zero to the mix.
   assign src0 = got0_q ? cap0_q : 48'd0;
   assign src1 = got1_q ? cap1_q : 48'd0;
   assign mix  = {sat_add(src0[47:24], src1[47:24]), sat_add(src0[23:0], src1[23:0])};

   assign req0 = (mode_q != 2'd1);
   assign req1 = (mode_q != 2'd0);

   always_comb begin
      state_d  = state_q;
      mode_d   = mode_q;
      mute_d   = mute_q;
      cnt_d    = cnt_q;
      got0_d   = got0_q;
      got1_d   = got1_q;
      cap0_d   = cap0_q;
      cap1_d   = cap1_q;
      dac_d    = dac_q;
      s0_ready = 1'b0;
      s1_ready = 1'b0;
      load_und = 1'b0;
      done     = 1'b0;
      unique case (state_q)
         ST_WAIT: begin
            if (dac_ready) begin
               state_d = ST_FETCH;
               mode_d  = mode;
               mute_d  = mute;
               cnt_d   = '0;
               got0_d  = 1'b0;
               got1_d  = 1'b0;
               cap0_d  = '0;
               cap1_d  = '0;
            end
         end
         ST_FETCH: begin
            s0_ready = req0 & ~got0_q;
            s1_ready = req1 & ~got1_q;
            if (s0_valid && s0_ready) begin
               got0_d = 1'b1;
               cap0_d = s0_data;
            end
            if (s1_valid && s1_ready) begin
               got1_d = 1'b1;
               cap1_d = s1_data;
            end
            cnt_d = cnt_q + 1'b1;
            // Priority mode finishes on s1 alone; s0 only serves as timeout fallback.
            unique case (mode_q)
               2'd0:    done = got0_d;
               2'd1:    done = got1_d;
               2'd2:    done = got1_d;
               default: done = got0_d & got1_d;
            endcase
            if (done || cnt_q == TMO_LAST) begin
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            state_d = ST_WAIT;
            unique case (mode_q)
               2'd0: begin
                  dac_d    = src0;
                  load_und = ~got0_q;
               end
               2'd1: begin
                  dac_d    = src1;
                  load_und = ~got1_q;
               end
               2'd2: begin
                  dac_d    = got1_q ? src1 : src0;
                  load_und = ~got0_q & ~got1_q;
               end
               default: begin
                  dac_d    = mix;
                  load_und = ~(got0_q & got1_q);
               end
            endcase
            if (mute_q) begin
               dac_d = '0;
            end
         end
         default: state_d = ST_WAIT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_WAIT;
         mode_q  <= '0;
         mute_q  <= 1'b0;
         cnt_q   <= '0;
         got0_q  <= 1'b0;
         got1_q  <= 1'b0;
         cap0_q  <= '0;
         cap1_q  <= '0;
         dac_q   <= '0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         mute_q  <= mute_d;
         cnt_q   <= cnt_d;
         got0_q  <= got0_d;
         got1_q  <= got1_d;
         cap0_q  <= cap0_d;
         cap1_q  <= cap1_d;
         dac_q   <= dac_d;
      end
   end

   assign dac_data = dac_q;

   // A DAC read while a refill is still in progress means it re-read a stale sample.
   assign underrun = load_und | ((state_q != ST_WAIT) & dac_ready);

`ifdef PSOC_DAC_SCHED_STATS_EN
   logic [CNT_W-1:0] ucnt_q, ucnt_d;

   always_comb begin
      ucnt_d = ucnt_q;
      if (clr_stats) begin
         ucnt_d = '0;
      end else if (underrun && !(&ucnt_q)) begin
         ucnt_d = ucnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ucnt_q <= '0;
      end else begin
         ucnt_q <= ucnt_d;
      end
   end

   assign underrun_cnt = ucnt_q;
`endif

endmodule

// File: tb/tb_psoc_dac_sched.sv
// tb/tb_psoc_dac_sched.sv - self-checking bench for psoc_dac_sched
module tb_psoc_dac_sched;

   localparam int TMO = 16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  mode;
   logic        mute;
   logic [47:0] s0_data, s1_data;
   logic        s0_valid, s1_valid;
   logic        s0_ready, s1_ready;
   logic [47:0] dac_data;
   logic        dac_ready;
   logic        underrun;
`ifdef PSOC_DAC_SCHED_STATS_EN
   logic        clr_stats;
   logic [15:0] underrun_cnt;
`endif

   int checks = 0;
   int errors = 0;
   int hs0 = 0, hs1 = 0, und = 0;
   int b0, b1, bu;
   logic [47:0] exp_q[$];
   logic [47:0] exp_v;

   always #5 clk = ~clk;

   psoc_dac_sched #(.TIMEOUT(TMO)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .mode     (mode),
      .mute     (mute),
      .s0_data  (s0_data),
      .s0_valid (s0_valid),
      .s0_ready (s0_ready),
      .s1_data  (s1_data),
      .s1_valid (s1_valid),
      .s1_ready (s1_ready),
      .dac_data (dac_data),
      .dac_ready(dac_ready),
      .underrun (underrun)
`ifdef PSOC_DAC_SCHED_STATS_EN
      , .clr_stats   (clr_stats)
      , .underrun_cnt(underrun_cnt)
`endif
   );

   always @(negedge clk) begin
      if (s0_valid && s0_ready) hs0++;
      if (s1_valid && s1_ready) hs1++;
      if (underrun) und++;
   end

   task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic snap();
      b0 = hs0; b1 = hs1; bu = und;
   endtask

   // Returns one cycle after dac_ready was sampled (first FETCH cycle, t+1).
   task automatic pulse();
      @(posedge clk); #1 dac_ready = 1'b1;
      @(posedge clk); #1 dac_ready = 1'b0;
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pop_chk(input string tag);
      exp_v = exp_q.pop_front();
      chk(tag, dac_data, exp_v);
   endtask

   initial begin
      rst_n = 1'b0; mode = 2'd0; mute = 1'b0; dac_ready = 1'b0;
      s0_data = '0; s1_data = '0; s0_valid = 1'b0; s1_valid = 1'b0;
`ifdef PSOC_DAC_SCHED_STATS_EN
      clr_stats = 1'b0;
`endif
      cyc(3);
      chk("rst_dac", dac_data, 48'd0);
      chk("rst_s0r", {47'd0, s0_ready}, 48'd0);
      chk("rst_s1r", {47'd0, s1_ready}, 48'd0);
      chk("rst_und", {47'd0, underrun}, 48'd0);
      rst_n = 1'b1;
      cyc(2);

      // No valid source: underrun only after the timeout, sample zero.
      snap(); exp_q.push_back(48'd0);
      pulse(); cyc(2);
      chk("nov_und_early", 48'(und - bu), 48'd0);
      cyc(TMO + 2);
      chk("nov_und", 48'(und - bu), 48'd1);
      pop_chk("nov_dac");

      // Mode 0 latency: new sample exactly at t+3.
      mode = 2'd0; s0_data = 48'h000010_000020; s0_valid = 1'b1;
      snap(); exp_q.push_back(48'h000010_000020);
      pulse(); cyc(1);
      chk("m0_dac_t2", dac_data, 48'd0);
      cyc(1);
      pop_chk("m0_dac_t3");
      cyc(3);
      chk("m0_hs0", 48'(hs0 - b0), 48'd1);
      chk("m0_und", 48'(und - bu), 48'd0);
      s0_valid = 1'b0;

      // Priority with both valid: s1 wins.
      mode = 2'd2; s0_data = 48'h111111_222222; s1_data = 48'h333333_444444;
      s0_valid = 1'b1; s1_valid = 1'b1;
      snap(); exp_q.push_back(48'h333333_444444);
      pulse(); cyc(2);
      pop_chk("m2_both_dac");
      cyc(5);
      chk("m2_hs0_le1", {47'd0, (hs0 - b0) <= 1}, 48'd1);
      chk("m2_hs1", 48'(hs1 - b1), 48'd1);
      chk("m2_und", 48'(und - bu), 48'd0);
      s0_valid = 1'b0; s1_valid = 1'b0;

      // Priority, s1 absent: s0 after timeout, no underrun.
      s0_valid = 1'b1; s0_data = 48'h0000AB_0000CD;
      snap(); exp_q.push_back(48'h0000AB_0000CD);
      pulse(); cyc(TMO + 2);
      pop_chk("m2_to_dac");
      chk("m2_to_und", 48'(und - bu), 48'd0);
      chk("m2_to_hs0", 48'(hs0 - b0), 48'd1);
      s0_valid = 1'b0;

      // Mix with saturation on both channels.
      mode = 2'd3; s0_data = {24'h800000, 24'h7FFFFF}; s1_data = {24'hFFFFFF, 24'h000001};
      s0_valid = 1'b1; s1_valid = 1'b1;
      exp_q.push_back({24'h800000, 24'h7FFFFF});
      pulse(); cyc(2);
      pop_chk("m3_sat");
      // Mix without saturation, mixed signs.
      s0_data = {24'h000005, 24'h000003}; s1_data = {24'hFFFFFE, 24'h000004};
      exp_q.push_back({24'h000003, 24'h000007});
      pulse(); cyc(2);
      pop_chk("m3_plain");
      s1_valid = 1'b0;

      // Mix with s1 missing: s0 alone, underrun.
      s0_data = {24'h000002, 24'h000001};
      snap(); exp_q.push_back({24'h000002, 24'h000001});
      pulse(); cyc(TMO + 2);
      pop_chk("m3_miss_dac");
      chk("m3_miss_und", 48'(und - bu), 48'd1);
      s0_valid = 1'b0;

      // Mode 1.
      mode = 2'd1; s1_data = 48'hABCDEF_123456; s1_valid = 1'b1;
      snap(); exp_q.push_back(48'hABCDEF_123456);
      pulse(); cyc(2);
      pop_chk("m1_dac");
      cyc(2);
      chk("m1_hs1", 48'(hs1 - b1), 48'd1);
      s1_valid = 1'b0;

      // Mute, frozen on FETCH entry; dac_ready while fetching.
      mode = 2'd0; mute = 1'b1; s0_data = 48'h555555_666666;
      snap(); exp_q.push_back(48'd0);
      pulse();
      mute = 1'b0; dac_ready = 1'b1;
      @(posedge clk); #1 dac_ready = 1'b0; s0_valid = 1'b1;
      chk("mute_dac_hold", dac_data, 48'hABCDEF_123456);
      cyc(4);
      s0_valid = 1'b0;
      pop_chk("mute_dac");
      chk("mute_hs0", 48'(hs0 - b0), 48'd1);
      chk("mute_und", 48'(und - bu), 48'd1);

      // Asynchronous reset in the middle of a fetch.
      mode = 2'd3;
      pulse();
      s0_data = 48'h777777_777777; s0_valid = 1'b1;
      cyc(1);
      s0_data = 48'h123123_123123;
      mode = 2'd0;
      s0_valid = 1'b0;
      exp_q.push_back(48'h0);
      exp_q.push_back(48'h0);
      pulse();
      s0_valid = 1'b1; s0_data = 48'h0A0A0A_0B0B0B;
      cyc(2);
      pop_chk("pre_rst_dac");
      s0_valid = 1'b0;
      exp_q.pop_front();
      mode = 2'd1;
      exp_q.push_back(48'd0);
      pulse();
      #2 rst_n = 1'b0;
      #1;
      pop_chk("arst_dac");
      chk("arst_s1r", {47'd0, s1_ready}, 48'd0);
      cyc(1);
      rst_n = 1'b1;
      cyc(2);

`ifdef PSOC_DAC_SCHED_STATS_EN
      mode = 2'd0;
      clr_stats = 1'b1; cyc(1); clr_stats = 1'b0;
      repeat (3) begin
         pulse(); cyc(TMO + 2);
      end
      chk("st_cnt3", 48'(underrun_cnt), 48'd3);
      pulse();
      dac_ready = 1'b1; clr_stats = 1'b1;
      @(posedge clk); #1 dac_ready = 1'b0; clr_stats = 1'b0;
      chk("st_clr_win", 48'(underrun_cnt), 48'd0);
      cyc(TMO + 2);
      chk("st_cnt1", 48'(underrun_cnt), 48'd1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
